// File: rtl/sqrt_path.sv
// sqrt_path: datapath for an iterative integer square root, floor(sqrt(a)).
// Ports:
//   clk, clr            - clock and synchronous active-high reset
//   ald, sqld, dld      - controller strobes: load radicand, sq+=del, del+=2
//   outld               - level-held result request; its rising edge captures root
//   a_in                - unsigned radicand, sampled only when ald is high
//   lteflg              - status to the controller, (sq <= a)
//   root, res_valid     - result register and valid flag
//   res_ready           - consumer handshake
//   overrun             - sticky flag, a captured result was dropped
//   iter_cnt            - number of update iterations (saturating)
module sqrt_path #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               ald,
    input  logic               sqld,
    input  logic               dld,
    input  logic               outld,
    input  logic [WIDTH-1:0]   a_in,
    output logic               lteflg,
    output logic [WIDTH/2-1:0] root,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               overrun,
    output logic [WIDTH/2:0]   iter_cnt
);

    localparam int HW = WIDTH / 2;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   sq_q, sq_d;
    logic [HW+1:0]    del_q, del_d;
    logic             outld_q;
    logic [HW-1:0]    root_q, root_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [HW:0]      iter_q, iter_d;

    logic             capture;
    logic             slot_free;
    logic [HW+1:0]    half_m1;

    assign lteflg    = (sq_q <= {1'b0, a_q});
    assign capture   = outld & ~outld_q;
    // The result slot can take a new value if empty or drained this edge.
    assign slot_free = ~valid_q | res_ready;
    // After the loop exits, del = 2*root + 3, so root = del/2 - 1.
    assign half_m1   = (del_q >> 1) - (HW+2)'(1);

    always_comb begin
        a_d     = a_q;
        sq_d    = sq_q;
        del_d   = del_q;
        iter_d  = iter_q;
        root_d  = root_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (ald) begin
            a_d    = a_in;
            sq_d   = (WIDTH+1)'(1);
            del_d  = (HW+2)'(3);
            iter_d = '0;
        end else begin
            if (sqld)
                sq_d = sq_q + (WIDTH+1)'(del_q);
            if (dld) begin
                del_d = del_q + (HW+2)'(2);
                if (iter_q != '1)
                    iter_d = iter_q + (HW+1)'(1);
            end
        end

        if (capture) begin
            if (slot_free) begin
                root_d  = half_m1[HW-1:0];
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && res_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            a_q     <= '0;
            sq_q    <= (WIDTH+1)'(1);
            del_q   <= (HW+2)'(3);
            outld_q <= 1'b0;
            root_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            iter_q  <= '0;
        end else begin
            a_q     <= a_d;
            sq_q    <= sq_d;
            del_q   <= del_d;
            outld_q <= outld;
            root_q  <= root_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            iter_q  <= iter_d;
        end
    end

    assign root      = root_q;
    assign res_valid = valid_q;
    assign overrun   = ovr_q;
    assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_sqrt_path.sv
// tb_sqrt_path: directed bench for sqrt_path (WIDTH=8).
// Drives a simple controller loop and checks results against hand values.
module tb_sqrt_path;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       ald = 1'b0;
    logic       sqld = 1'b0;
    logic       dld = 1'b0;
    logic       outld = 1'b0;
    logic [7:0] a_in = '0;
    logic       lteflg;
    logic [3:0] root;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       overrun;
    logic [4:0] iter_cnt;

    int total = 0;
    int bad = 0;
    int n;

    sqrt_path #(.WIDTH(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .ald       (ald),
        .sqld      (sqld),
        .dld       (dld),
        .outld     (outld),
        .a_in      (a_in),
        .lteflg    (lteflg),
        .root      (root),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .overrun   (overrun),
        .iter_cnt  (iter_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Controller: load, then update while sq <= a; returns update count.
    task automatic compute(input logic [7:0] val, output int cnt);
        a_in = val;
        ald = 1'b1;
        step();
        ald = 1'b0;
        a_in = 8'hA5;
        cnt = 0;
        while (lteflg && cnt < 40) begin
            sqld = 1'b1;
            dld = 1'b1;
            step();
            cnt++;
        end
        sqld = 1'b0;
        dld = 1'b0;
    endtask

    task automatic pulse_outld(input logic rdy);
        res_ready = rdy;
        outld = 1'b1;
        step();
        outld = 1'b0;
        res_ready = 1'b0;
        step();
    endtask

    task automatic consume();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("rst_lteflg", lteflg, 0);
        chk("rst_root", root, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_iter", iter_cnt, 0);

        // a = 0
        compute(8'd0, n);
        chk("a0_updates", n, 0);
        chk("a0_lteflg", lteflg, 0);
        pulse_outld(1'b0);
        chk("a0_root", root, 0);
        chk("a0_iter", iter_cnt, 0);
        chk("a0_valid", res_valid, 1);
        consume();
        chk("a0_consumed", res_valid, 0);

        // a = 16
        compute(8'd16, n);
        chk("a16_updates", n, 4);
        chk("a16_iter", iter_cnt, 4);
        pulse_outld(1'b0);
        chk("a16_root", root, 4);
        chk("a16_valid", res_valid, 1);
        consume();
        chk("a16_consumed", res_valid, 0);

        // a = 255, max radicand
        compute(8'd255, n);
        chk("a255_updates", n, 15);
        chk("a255_iter", iter_cnt, 15);
        chk("a255_sq", int'(dut.sq_q), 256);
        pulse_outld(1'b0);
        chk("a255_root", root, 15);
        consume();

        // outld held 6 cycles, ready on cycle 3 only
        compute(8'd16, n);
        outld = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            res_ready = (c == 3);
            step();
            chk($sformatf("hold_valid_c%0d", c), res_valid, (c < 3) ? 1 : 0);
        end
        res_ready = 1'b0;
        outld = 1'b0;
        step();
        chk("hold_after", res_valid, 0);
        chk("hold_overrun", overrun, 0);

        // Capture coinciding with consume: new root, no overrun
        compute(8'd9, n);
        pulse_outld(1'b0);
        chk("a9_root", root, 3);
        compute(8'd49, n);
        chk("a49_updates", n, 7);
        chk("a9_kept_during_ald", root, 3);
        pulse_outld(1'b1);
        chk("coinc_root", root, 7);
        chk("coinc_valid", res_valid, 1);
        chk("coinc_overrun", overrun, 0);

        // Capture while unconsumed: drop, overrun
        compute(8'd9, n);
        pulse_outld(1'b0);
        chk("ovr_root_kept", root, 7);
        chk("ovr_valid", res_valid, 1);
        chk("ovr_flag", overrun, 1);
        consume();
        chk("ovr_drained", res_valid, 0);
        step();
        chk("ovr_sticky", overrun, 1);

        // ald overrides sqld/dld
        a_in = 8'd16;
        ald = 1'b1;
        sqld = 1'b1;
        dld = 1'b1;
        step();
        ald = 1'b0;
        sqld = 1'b0;
        dld = 1'b0;
        chk("ald_pri_iter", iter_cnt, 0);
        chk("ald_pri_lteflg", lteflg, 1);

        // iter_cnt saturation
        dld = 1'b1;
        repeat (35) step();
        dld = 1'b0;
        chk("iter_sat", iter_cnt, 31);

        // Mid-operation clr
        a_in = 8'd100;
        ald = 1'b1;
        step();
        ald = 1'b0;
        sqld = 1'b1;
        dld = 1'b1;
        repeat (2) step();
        sqld = 1'b0;
        dld = 1'b0;
        chk("mid_iter2", iter_cnt, 2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_iter", iter_cnt, 0);
        chk("clr_lteflg", lteflg, 0);
        chk("clr_valid", res_valid, 0);
        chk("clr_overrun", overrun, 0);
        chk("clr_root", root, 0);
        compute(8'd100, n);
        chk("a100_updates", n, 10);
        chk("a100_iter", iter_cnt, 10);
        pulse_outld(1'b0);
        chk("a100_root", root, 10);

        // outld high through clr: first post-reset cycle captures
        outld = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_outld_valid0", res_valid, 0);
        step();
        chk("clr_outld_capture", res_valid, 1);
        chk("clr_outld_root", root, 0);
        outld = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
